// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer between the execute stage and the shared
// signed/unsigned AXI-Stream divider pair used by DIV/DIVU.
// It latches the operands, drives both operand handshakes, waits for the
// quotient/remainder, and writes HI/LO. A flush squashes the op in flight.
// Stale divider results are drained so they never reach HI/LO.
module div_seq_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic                op_signed,
  input  logic [DATA_W-1:0]   op_dividend,
  input  logic [DATA_W-1:0]   op_divisor,
  input  logic                pipe_allowin,
  input  logic                flush,
  output logic                op_ready_go,
  output logic                busy,
  output logic                s_dividend_tvalid,
  input  logic                s_dividend_tready,
  output logic                s_divisor_tvalid,
  input  logic                s_divisor_tready,
  output logic                s_sel_signed,
  output logic [DATA_W-1:0]   s_dividend_tdata,
  output logic [DATA_W-1:0]   s_divisor_tdata,
  input  logic                m_dout_tvalid,
  input  logic [2*DATA_W-1:0] m_dout_tdata,
  output logic                hilo_we,
  output logic [DATA_W-1:0]   lo_wdata,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic                err_timeout
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  // Last counter value before the abort fires, giving TIMEOUT_CYC cycles in WAIT/DRAIN.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              dvd_sent_q, dvd_sent_d;
  logic              dvs_sent_q, dvs_sent_d;
  logic              killed_q, killed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;

  logic dvd_hs, dvs_hs, dvd_done, dvs_done, tmo_hit;

  assign s_dividend_tvalid = (state_q == S_SEND) && !dvd_sent_q;
  assign s_divisor_tvalid  = (state_q == S_SEND) && !dvs_sent_q;
  assign dvd_hs            = s_dividend_tvalid && s_dividend_tready;
  assign dvs_hs            = s_divisor_tvalid && s_divisor_tready;
  // A channel counts as done if it was sent earlier or handshakes this cycle.
  assign dvd_done          = dvd_sent_q || dvd_hs;
  assign dvs_done          = dvs_sent_q || dvs_hs;
  assign tmo_hit           = (cnt_q == CNT_LAST);

  assign op_ready_go      = (state_q == S_DONE);
  assign busy             = (state_q != S_IDLE);
  assign s_sel_signed     = signed_q;
  assign s_dividend_tdata = dividend_q;
  assign s_divisor_tdata  = divisor_q;
  assign err_timeout      = err_q;
  assign lo_wdata         = hilo_we ? m_dout_tdata[2*DATA_W-1:DATA_W] : '0;
  assign hi_wdata         = hilo_we ? m_dout_tdata[DATA_W-1:0] : '0;

  // Next-state, handshake bookkeeping, timeout, and the HI/LO write strobe.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    dvd_sent_d = dvd_sent_q;
    dvs_sent_d = dvs_sent_q;
    killed_d   = killed_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    err_d      = err_q;
    hilo_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          state_d    = S_SEND;
          dividend_d = op_dividend;
          divisor_d  = op_divisor;
          signed_d   = op_signed;
          dvd_sent_d = 1'b0;
          dvs_sent_d = 1'b0;
          killed_d   = 1'b0;
        end
      end

      S_SEND: begin
        dvd_sent_d = dvd_done;
        dvs_sent_d = dvs_done;
        if (dvd_done && dvs_done) begin
          // The divider owns both operands and will answer, so a killed op must drain.
          state_d = (killed_q || flush) ? S_DRAIN : S_WAIT;
          cnt_d   = '0;
        end else if (flush) begin
          // Nothing reached the divider yet, so it can be abandoned outright.
          if (!dvd_done && !dvs_done) state_d  = S_IDLE;
          else                        killed_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (m_dout_tvalid && !flush) begin
          hilo_we = 1'b1;
          state_d = S_DONE;
        end else if (flush) begin
          // A result arriving with the flush is already consumed; no drain needed.
          state_d = m_dout_tvalid ? S_IDLE : S_DRAIN;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        if (m_dout_tvalid) begin
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (pipe_allowin || flush) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and operand registers; the divider IP shares this reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: operand holding registers are reset too, so the tdata outputs read 0 out of reset.
    if (reset) begin
      state_q    <= S_IDLE;
      dvd_sent_q <= 1'b0;
      dvs_sent_q <= 1'b0;
      killed_q   <= 1'b0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      dvd_sent_q <= dvd_sent_d;
      dvs_sent_q <= dvs_sent_d;
      killed_q   <= killed_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: emulates the divider pair with configurable tready delays and
// result latency. It drives directed and random DIV/DIVU ops with flushes.
// Each op is checked against a cycle-level model of the sequencing rules.
module tb_div_seq_ctrl;

  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 63;

  logic                clk;
  logic                reset;
  logic                op_valid;
  logic                op_signed;
  logic [DATA_W-1:0]   op_dividend;
  logic [DATA_W-1:0]   op_divisor;
  logic                pipe_allowin;
  logic                flush;
  logic                op_ready_go;
  logic                busy;
  logic                s_dividend_tvalid;
  logic                s_dividend_tready;
  logic                s_divisor_tvalid;
  logic                s_divisor_tready;
  logic                s_sel_signed;
  logic [DATA_W-1:0]   s_dividend_tdata;
  logic [DATA_W-1:0]   s_divisor_tdata;
  logic                m_dout_tvalid;
  logic [2*DATA_W-1:0] m_dout_tdata;
  logic                hilo_we;
  logic [DATA_W-1:0]   lo_wdata;
  logic [DATA_W-1:0]   hi_wdata;
  logic                err_timeout;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          exp_err  = 1'b0;
  logic [31:0] last_lo, last_hi;
  int          last_idle;

  div_seq_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk               (clk),
    .reset             (reset),
    .op_valid          (op_valid),
    .op_signed         (op_signed),
    .op_dividend       (op_dividend),
    .op_divisor        (op_divisor),
    .pipe_allowin      (pipe_allowin),
    .flush             (flush),
    .op_ready_go       (op_ready_go),
    .busy              (busy),
    .s_dividend_tvalid (s_dividend_tvalid),
    .s_dividend_tready (s_dividend_tready),
    .s_divisor_tvalid  (s_divisor_tvalid),
    .s_divisor_tready  (s_divisor_tready),
    .s_sel_signed      (s_sel_signed),
    .s_dividend_tdata  (s_dividend_tdata),
    .s_divisor_tdata   (s_divisor_tdata),
    .m_dout_tvalid     (m_dout_tvalid),
    .m_dout_tdata      (m_dout_tdata),
    .hilo_we           (hilo_we),
    .lo_wdata          (lo_wdata),
    .hi_wdata          (hi_wdata),
    .err_timeout       (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    op_valid          = 1'b0;
    flush             = 1'b0;
    s_dividend_tready = 1'b0;
    s_divisor_tready  = 1'b0;
    m_dout_tvalid     = 1'b0;
    pipe_allowin      = 1'b0;
  endtask

  // One op: cycle 0 presents it in IDLE. The emulated divider raises each tready
  // at cycle 1+w and answers lat cycles after the later handshake (lat<0: never).
  // flush pulses at cycle flush_at (-1: none). DONE sees allowin after allow_w cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input int dvd_w, input int dvs_w, input int lat,
                       input int flush_at, input int allow_w);
    int cyc, dvd_cnt, dvs_cnt, dvd_hc, dvs_hc, dout_cyc, writes, rdy_n, first_rdy, idle_cyc;
    int first_hs, h, d, acc, e_idle, e_first_rdy, e_writes, e_hs, e_rdy_n;
    bit flushed, accepted, pre, killed, tmo;
    logic [31:0] q_exp, r_exp, wlo, whi;

    if (sgn) begin
      q_exp = $signed(a) / $signed(b);
      r_exp = $signed(a) % $signed(b);
    end else begin
      q_exp = a / b;
      r_exp = a % b;
    end

    cyc = 0; dvd_cnt = 0; dvs_cnt = 0; dvd_hc = -1; dvs_hc = -1; dout_cyc = -1;
    writes = 0; rdy_n = 0; first_rdy = -1; idle_cyc = -1;
    flushed = 1'b0; accepted = 1'b0; wlo = '0; whi = '0;

    while (idle_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      op_valid          = !flushed && !accepted;
      op_signed         = (cyc == 0) ? sgn : 1'($urandom_range(0, 1));
      op_dividend       = (cyc == 0) ? a : $urandom;
      op_divisor        = (cyc == 0) ? b : $urandom;
      flush             = (cyc == flush_at);
      s_dividend_tready = (cyc >= 1 + dvd_w);
      s_divisor_tready  = (cyc >= 1 + dvs_w);
      m_dout_tvalid     = (cyc == dout_cyc);
      m_dout_tdata      = (cyc == dout_cyc) ? {q_exp, r_exp} : {$urandom, $urandom};
      pipe_allowin      = (rdy_n >= allow_w);
      #1;
      if (s_dividend_tvalid && s_dividend_tready) begin
        dvd_cnt++;
        dvd_hc = cyc;
        check("dividend_tdata", 64'(s_dividend_tdata), 64'(a));
        check("sel_signed_dvd", 64'(s_sel_signed), 64'(sgn));
      end
      if (s_divisor_tvalid && s_divisor_tready) begin
        dvs_cnt++;
        dvs_hc = cyc;
        check("divisor_tdata", 64'(s_divisor_tdata), 64'(b));
        check("sel_signed_dvs", 64'(s_sel_signed), 64'(sgn));
      end
      if (dvd_hc >= 0 && dvs_hc >= 0 && dout_cyc < 0 && lat >= 0)
        dout_cyc = ((dvd_hc > dvs_hc) ? dvd_hc : dvs_hc) + lat;
      if (hilo_we) begin
        writes++;
        wlo = lo_wdata;
        whi = hi_wdata;
      end
      if (op_ready_go) begin
        rdy_n++;
        if (first_rdy < 0) first_rdy = cyc;
        if (pipe_allowin) accepted = 1'b1;
      end
      if (flush) flushed = 1'b1;
      if (cyc > 0 && !busy) idle_cyc = cyc;
      cyc++;
    end
    // Withdraw the op before the next edge so an aborted op is not restarted.
    idle_inputs();

    // Reference timing from the sequencing rules.
    first_hs = 1 + ((dvd_w < dvs_w) ? dvd_w : dvs_w);
    h        = 1 + ((dvd_w > dvs_w) ? dvd_w : dvs_w);
    d        = (lat >= 0) ? h + lat : -1;
    pre      = (flush_at >= 1) && (flush_at < first_hs);
    killed   = !pre && (flush_at >= 1) && (lat < 0 || flush_at <= d);
    tmo      = (lat < 0) && !pre && !killed;
    e_hs        = pre ? 0 : 1;
    e_first_rdy = -1;
    e_writes    = 0;
    if (pre)         e_idle = flush_at + 1;
    else if (tmo)    e_idle = h + TIMEOUT_CYC + 1;
    else if (killed) e_idle = d + 1;
    else begin
      e_first_rdy = d + 1;
      e_writes    = 1;
      acc         = e_first_rdy + allow_w;
      e_idle      = (flush_at >= e_first_rdy && flush_at <= acc) ? flush_at + 1 : acc + 1;
    end
    e_rdy_n = (e_first_rdy < 0) ? 0 : e_idle - e_first_rdy;
    if (tmo) exp_err = 1'b1;

    check("dividend_handshakes", 64'(dvd_cnt), 64'(e_hs));
    check("divisor_handshakes", 64'(dvs_cnt), 64'(e_hs));
    check("hilo_writes", 64'(writes), 64'(e_writes));
    if (e_writes == 1 && writes == 1) begin
      check("lo_quotient", 64'(wlo), 64'(q_exp));
      check("hi_remainder", 64'(whi), 64'(r_exp));
    end
    check("first_ready_cycle", 64'(first_rdy), 64'(e_first_rdy));
    check("ready_go_cycles", 64'(rdy_n), 64'(e_rdy_n));
    check("idle_cycle", 64'(idle_cyc), 64'(e_idle));
    check("err_timeout", 64'(err_timeout), 64'(exp_err));
    last_lo   = wlo;
    last_hi   = whi;
    last_idle = idle_cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          fa;

    reset       = 1'b1;
    op_signed   = 1'b0;
    op_dividend = '0;
    op_divisor  = '0;
    m_dout_tdata = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready_go", 64'(op_ready_go), 64'd0);
    check("rst_dvd_tvalid", 64'(s_dividend_tvalid), 64'd0);
    check("rst_dvs_tvalid", 64'(s_divisor_tvalid), 64'd0);
    check("rst_hilo_we", 64'(hilo_we), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_tdata", 64'({s_dividend_tdata, s_divisor_tdata}), 64'd0);
    check("rst_sel", 64'(s_sel_signed), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // DIVU 100/7, divider answers 10 cycles after the handshake.
    do_op(32'd100, 32'd7, 1'b0, 0, 0, 10, -1, 0);
    check("t1_lo_const", 64'(last_lo), 64'd14);
    check("t1_hi_const", 64'(last_hi), 64'd2);
    // DIV -7/2, tready on cycles 2 and 4.
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1, 3, 4, -1, 1);
    check("t2_lo_const", 64'(last_lo), 64'h0000_0000_FFFF_FFFD);
    check("t2_hi_const", 64'(last_hi), 64'h0000_0000_FFFF_FFFF);
    // Flush in WAIT at cycle 5, stale dout at cycle 10, IDLE at cycle 11.
    do_op(32'd77, 32'd5, 1'b0, 0, 0, 9, 5, 0);
    check("t3_idle_const", 64'(last_idle), 64'd11);
    // Flush after the dividend handshake only; divisor still goes out once.
    do_op(32'd1000, 32'd3, 1'b0, 0, 4, 5, 2, 0);
    do_op(32'd1001, 32'd10, 1'b0, 0, 0, 3, -1, 0);
    // DONE held for three extra cycles.
    do_op(32'hFFFF_FF00, 32'd16, 1'b1, 0, 0, 3, -1, 3);
    // Flush while in DONE, and flush before any handshake.
    do_op(32'd50, 32'd5, 1'b0, 0, 0, 2, 4, 3);
    do_op(32'd9, 32'd3, 1'b0, 3, 3, 2, 2, 0);
    // Flush in the same cycle the result arrives.
    do_op(32'd12, 32'd4, 1'b0, 0, 0, 4, 5, 0);
    // Divider never answers.
    do_op(32'd1, 32'd1, 1'b0, 0, 0, -1, -1, 0);
    check("t6_idle_const", 64'(last_idle), 64'd65);
    // err_timeout stays set across a later op.
    do_op(32'd81, 32'd9, 1'b1, 1, 0, 2, -1, 0);

    // Async reset in WAIT drops back to IDLE without a clock edge.
    @(negedge clk);
    op_valid = 1'b1; op_signed = 1'b1; op_dividend = 32'd55; op_divisor = 32'd5;
    s_dividend_tready = 1'b1; s_divisor_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("arst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_err_cleared", 64'(err_timeout), 64'd0);
    check("arst_tdata", 64'(s_dividend_tdata), 64'd0);
    check("arst_sel", 64'(s_sel_signed), 64'd0);
    exp_err = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_00FF) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      rs = 1'($urandom_range(0, 1));
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      fa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : -1;
      do_op(ra, rb, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(1, 12)), fa, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
